// File: rtl/dff_arb_pkg.sv
// Shared types and the rotating first-one search for dff_reg_arbiter.
// The search is sized for the largest legal requester count (8).
package dff_arb_pkg;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int CNT_W    = 16;
   localparam int MAX_NREQ = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // First set bit of req[nreq-1:0] at or after ptr, wrapping modulo nreq.
   function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                     input logic [2:0]          ptr,
                                     input int                  nreq);
      pick_t res;
      int    j;
      res = '0;
      for (int i = 0; i < MAX_NREQ; i++) begin
         j = (int'(ptr) + i) % nreq;
         if (i < nreq && !res.found && req[j]) begin
            res.found = 1'b1;
            res.idx   = 3'(j);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dff_word.sv
// WIDTH-bit D flip-flop word with load enable and synchronous active-low clear.
module dff_word #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)  r_q <= '0;
      else if (i_en) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting one write per grant into a shared DFF register.
// Define DFF_ARB_LOCK_EN to add the lock input for back-to-back burst writes.
module dff_reg_arbiter
   import dff_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
   input  logic [NREQ-1:0]       lock,
`endif
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic                  q_valid,
   output logic [IDW-1:0]        owner,
   output logic [CNT_W-1:0]      wr_count
);

   state_t            r_state, w_state_nxt;
   logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
   logic [IDW-1:0]    r_win, w_win_nxt;
   logic [IDW-1:0]    r_ptr, w_ptr_nxt;
   logic [IDW-1:0]    r_owner;
   logic              r_q_valid;
   logic [CNT_W-1:0]  r_wr_count;
   logic              w_wr_en;
   logic              w_hold;
   logic [WIDTH-1:0]  w_wdata_win;
   logic [MAX_NREQ-1:0] w_req8;
   pick_t             w_pick;

   always_comb begin
      w_req8             = '0;
      w_req8[NREQ-1:0]   = req;
   end

   assign w_pick      = rr_pick(w_req8, 3'(r_ptr), NREQ);
   assign w_wdata_win = wdata[r_win*WIDTH +: WIDTH];

`ifdef DFF_ARB_LOCK_EN
   // Winner keeps the grant while it both requests and locks.
   assign w_hold = req[r_win] && lock[r_win];
`else
   assign w_hold = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = '0;
      w_win_nxt   = r_win;
      w_ptr_nxt   = r_ptr;
      w_wr_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick.found) begin
               w_gnt_nxt   = NREQ'(1) << w_pick.idx;
               w_win_nxt   = IDW'(w_pick.idx);
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            // A withdrawn request at the closing edge skips the write.
            w_wr_en = req[r_win];
            if (w_hold) begin
               w_gnt_nxt   = r_gnt;
               w_state_nxt = GRANT;
            end else begin
               w_ptr_nxt   = (r_win == IDW'(NREQ-1)) ? '0 : r_win + IDW'(1);
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_win      <= '0;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_q_valid  <= 1'b0;
         r_wr_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_win   <= w_win_nxt;
         r_ptr   <= w_ptr_nxt;
         if (w_wr_en) begin
            r_owner    <= r_win;
            r_q_valid  <= 1'b1;
            r_wr_count <= r_wr_count + CNT_W'(1);
         end
      end
   end

   dff_word #(.WIDTH(WIDTH)) u_q (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_en    (w_wr_en),
      .i_d     (w_wdata_win),
      .o_q     (q)
   );

   assign gnt      = r_gnt;
   assign q_valid  = r_q_valid;
   assign owner    = r_owner;
   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model. Honours DFF_ARB_LOCK_EN like the design.
module tb_dff_reg_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = $clog2(NREQ);

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       lock;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic                  q_valid;
   logic [IDW-1:0]        owner;
   logic [15:0]           wr_count;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: cur = requester currently holding the grant, -1 if none.
   int m_cur, m_ptr, m_q, m_qv, m_owner, m_cnt;

   always #5 clk = ~clk;

   dff_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .wdata    (wdata),
`ifdef DFF_ARB_LOCK_EN
      .lock     (lock),
`endif
      .gnt      (gnt),
      .q        (q),
      .q_valid  (q_valid),
      .owner    (owner),
      .wr_count (wr_count)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit lock_on(input int i);
`ifdef DFF_ARB_LOCK_EN
      return lock[i];
`else
      return 1'b0;
`endif
   endfunction

   // Advances the model by one clock using the inputs present at the edge.
   task automatic model_step();
      int found;
      if (!reset) begin
         m_cur = -1; m_ptr = 0; m_q = 0; m_qv = 0; m_owner = 0; m_cnt = 0;
      end else if (m_cur < 0) begin
         found = -1;
         for (int k = 0; k < NREQ; k++)
            if (found < 0 && req[(m_ptr + k) % NREQ]) found = (m_ptr + k) % NREQ;
         m_cur = found;
      end else begin
         if (req[m_cur]) begin
            m_q     = int'(wdata[m_cur*WIDTH +: WIDTH]);
            m_qv    = 1;
            m_owner = m_cur;
            m_cnt   = (m_cnt + 1) % 65536;
         end
         if (!(req[m_cur] && lock_on(m_cur))) begin
            m_ptr = (m_cur + 1) % NREQ;
            m_cur = -1;
         end
      end
   endtask

   task automatic cyc();
      int exp_gnt;
      @(posedge clk);
      model_step();
      #1;
      exp_gnt = (m_cur < 0) ? 0 : (1 << m_cur);
      chk("gnt",      int'(gnt),      exp_gnt);
      chk("q",        int'(q),        m_q);
      chk("q_valid",  int'(q_valid),  m_qv);
      chk("owner",    int'(owner),    m_owner);
      chk("wr_count", int'(wr_count), m_cnt);
   endtask

   task automatic set_slice(input int i, input int v);
      wdata[i*WIDTH +: WIDTH] = WIDTH'(v);
   endtask

   int rr_q[5] = '{'h10, 'h11, 'h12, 'h13, 'h10};
   int seen;
   int q_before, cnt_before;

   initial begin
      m_cur = -1; m_ptr = 0; m_q = 0; m_qv = 0; m_owner = 0; m_cnt = 0;
      reset = 1'b0; req = '0; wdata = '0; lock = '0;

      // Reset held with all requesting
      req = 4'b1111;
      repeat (3) begin
         cyc();
         chk("rst_gnt", int'(gnt), 0);
         chk("rst_q",   int'(q),   0);
      end
      req = '0; reset = 1'b1;
      cyc();

      // Single request
      req = 4'b0100; set_slice(2, 'hA5);
      cyc(); chk("single_gnt", int'(gnt), 'b0100);
      cyc(); chk("single_q", int'(q), 'hA5);
      chk("single_owner", int'(owner), 2);
      chk("single_cnt", int'(wr_count), 1);
      req = '0; cyc();

      // Round robin from ptr 0
      reset = 1'b0; cyc(); reset = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_slice(i, 'h10 + i);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (c % 2 == 1) begin
            chk("rr_q", int'(q), rr_q[seen]);
            seen++;
         end
      end
      chk("rr_cnt", int'(wr_count), 5);
      req = '0; cyc(); cyc();

      // Withdraw during GRANT
      reset = 1'b0; cyc(); reset = 1'b1;
      req = 4'b0010; set_slice(1, 'h77);
      cyc(); chk("wd_gnt", int'(gnt), 'b0010);
      q_before = int'(q); cnt_before = int'(wr_count);
      req = 4'b0000;
      cyc(); chk("wd_q", int'(q), q_before);
      chk("wd_cnt", int'(wr_count), cnt_before);
      req = 4'b0110;
      cyc(); chk("wd_next", int'(gnt), 'b0100);
      cyc(); req = '0; cyc();

      // Reset in the GRANT cycle
      req = 4'b1111;
      cyc();
      reset = 1'b0;
      cyc(); chk("mid_gnt", int'(gnt), 0); chk("mid_q", int'(q), 0);
      reset = 1'b1;
      cyc(); chk("mid_ptr0", int'(gnt), 'b0001);
      req = '0; cyc(); cyc();

`ifdef DFF_ARB_LOCK_EN
      reset = 1'b0; cyc(); reset = 1'b1;
      req = 4'b0011; lock = 4'b0001; set_slice(0, 1);
      cyc(); chk("lk_gnt", int'(gnt), 'b0001);
      cyc(); chk("lk_q1", int'(q), 1); chk("lk_hold", int'(gnt), 'b0001);
      set_slice(0, 2);
      cyc(); chk("lk_q2", int'(q), 2);
      set_slice(0, 3); lock = 4'b0000;
      cyc(); chk("lk_q3", int'(q), 3); chk("lk_end", int'(gnt), 0);
      cyc(); chk("lk_next", int'(gnt), 'b0010);
      req = '0; cyc();
`endif

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 60) != 0);
         req   = NREQ'($urandom) & NREQ'($urandom | $urandom);
         wdata = (NREQ*WIDTH)'($urandom);
         lock  = NREQ'($urandom);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
